// File: rtl/reset_sequencer_pkg.sv
// Shared types and constants for the FlippyBit reset sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HOLD,
    ST_WAIT2,
    ST_ACK2,
    ST_WAIT1,
    ST_ACK1,
    ST_WAIT0,
    ST_ACK0
  } state_t;

  localparam logic [1:0] CAUSE_POWERUP  = 2'b00;
  localparam logic [1:0] CAUSE_BUTTON   = 2'b01;
  localparam logic [1:0] CAUSE_GAMEOVER = 2'b10;
  localparam logic [1:0] CAUSE_FAULT    = 2'b11;

  localparam int STAGE_0 = 0;
  localparam int STAGE_1 = 1;
  localparam int STAGE_2 = 2;

  function automatic bit fits_width(input longint unsigned value, input int unsigned width);
    if (width >= 64) return 1'b1;
    return value < (64'd1 << width);
  endfunction

endpackage

// File: rtl/reset_sequencer_seq_timer.sv
// Shared delay counter; o_expire is high on the last cycle of a target-length interval.
module seq_timer #(
  parameter int unsigned CNT_W = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_clear,
  input  logic [CNT_W-1:0] i_target,
  output logic             o_expire
);

  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_last;

  // A target of zero behaves like a target of one.
  always_comb begin
    w_last = '0;
    if (i_target != '0) w_last = i_target - CNT_W'(1);
  end

  assign o_expire = (r_count == w_last);

  always_ff @(posedge clock or posedge reset) begin
    if (reset)        r_count <= '0;
    else if (i_clear) r_count <= '0;
    else              r_count <= r_count + CNT_W'(1);
  end

endmodule

// File: rtl/reset_sequencer.sv
// Staged release of the three subsystem resets (2 -> 1 -> 0) with request
// arbitration and ack-timeout fault restart.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int unsigned     CNT_W         = 32,
  parameter longint unsigned HOLD_CYCLES   = 1000,
  parameter longint unsigned STAGE_DELAY_2 = 50000000,
  parameter longint unsigned STAGE_DELAY_1 = 200000000,
  parameter longint unsigned STAGE_DELAY_0 = 250000000,
  parameter longint unsigned ACK_TIMEOUT   = 1000000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_button,
  input  logic       req_gameover,
  input  logic [2:0] stage_ack,
  output logic [2:0] reset_out,
  output logic       busy,
  output logic       done,
  output logic [1:0] cause
);

  if (!(fits_width(HOLD_CYCLES, CNT_W) && fits_width(STAGE_DELAY_2, CNT_W) &&
        fits_width(STAGE_DELAY_1, CNT_W) && fits_width(STAGE_DELAY_0, CNT_W) &&
        fits_width(ACK_TIMEOUT, CNT_W))) begin : g_param_check
    $error("reset_sequencer: a delay parameter does not fit in CNT_W bits");
  end

  localparam logic [CNT_W-1:0] L_HOLD = CNT_W'(HOLD_CYCLES);
  localparam logic [CNT_W-1:0] L_D2   = CNT_W'(STAGE_DELAY_2);
  localparam logic [CNT_W-1:0] L_D1   = CNT_W'(STAGE_DELAY_1);
  localparam logic [CNT_W-1:0] L_D0   = CNT_W'(STAGE_DELAY_0);
  localparam logic [CNT_W-1:0] L_TO   = CNT_W'(ACK_TIMEOUT);

  state_t           r_state, w_state_nxt;
  logic             r_btn_q, r_go_q;
  logic             w_btn_edge, w_go_edge, w_fault, w_restart;
  logic             w_expire, w_timer_clear, w_ack_cur, w_in_ack;
  logic [CNT_W-1:0] w_target;
  logic [2:0]       r_reset_out, w_rst_nxt;
  logic             r_busy, r_done, w_busy_nxt, w_done_nxt;
  logic [1:0]       r_cause, w_cause_nxt;

  assign w_btn_edge = req_button & ~r_btn_q;
  assign w_go_edge  = req_gameover & ~r_go_q;

  always_comb begin
    w_target  = '0;
    w_ack_cur = 1'b0;
    w_in_ack  = 1'b0;
    case (r_state)
      ST_HOLD:  w_target = L_HOLD;
      ST_WAIT2: w_target = L_D2;
      ST_WAIT1: w_target = L_D1;
      ST_WAIT0: w_target = L_D0;
      ST_ACK2:  begin w_target = L_TO; w_in_ack = 1'b1; w_ack_cur = stage_ack[STAGE_2]; end
      ST_ACK1:  begin w_target = L_TO; w_in_ack = 1'b1; w_ack_cur = stage_ack[STAGE_1]; end
      ST_ACK0:  begin w_target = L_TO; w_in_ack = 1'b1; w_ack_cur = stage_ack[STAGE_0]; end
      default:  w_target = '0;
    endcase
  end

  assign w_fault   = w_in_ack & ~w_ack_cur & w_expire;
  assign w_restart = w_btn_edge | w_go_edge | w_fault;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_HOLD;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_restart) begin
      w_state_nxt = ST_HOLD;
    end else begin
      case (r_state)
        ST_HOLD:  if (w_expire)  w_state_nxt = ST_WAIT2;
        ST_WAIT2: if (w_expire)  w_state_nxt = ST_ACK2;
        ST_ACK2:  if (w_ack_cur) w_state_nxt = ST_WAIT1;
        ST_WAIT1: if (w_expire)  w_state_nxt = ST_ACK1;
        ST_ACK1:  if (w_ack_cur) w_state_nxt = ST_WAIT0;
        ST_WAIT0: if (w_expire)  w_state_nxt = ST_ACK0;
        ST_ACK0:  if (w_ack_cur) w_state_nxt = ST_IDLE;
        default:  w_state_nxt = r_state;
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    case (w_state_nxt)
      ST_HOLD, ST_WAIT2: w_rst_nxt = 3'b111;
      ST_ACK2, ST_WAIT1: w_rst_nxt = 3'b011;
      ST_ACK1, ST_WAIT0: w_rst_nxt = 3'b001;
      default:           w_rst_nxt = 3'b000;
    endcase
    w_busy_nxt  = (w_state_nxt != ST_IDLE);
    w_done_nxt  = (r_state == ST_ACK0) && (w_state_nxt == ST_IDLE);
    w_cause_nxt = r_cause;
    if (w_btn_edge)     w_cause_nxt = CAUSE_BUTTON;
    else if (w_go_edge) w_cause_nxt = CAUSE_GAMEOVER;
    else if (w_fault)   w_cause_nxt = CAUSE_FAULT;
  end

  assign w_timer_clear = w_restart | (w_state_nxt != r_state) | (r_state == ST_IDLE);

  seq_timer #(.CNT_W(CNT_W)) u_timer (
    .clock    (clock),
    .reset    (reset),
    .i_clear  (w_timer_clear),
    .i_target (w_target),
    .o_expire (w_expire)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_btn_q     <= 1'b0;
      r_go_q      <= 1'b0;
      r_reset_out <= 3'b111;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_cause     <= CAUSE_POWERUP;
    end else begin
      r_btn_q     <= req_button;
      r_go_q      <= req_gameover;
      r_reset_out <= w_rst_nxt;
      r_busy      <= w_busy_nxt;
      r_done      <= w_done_nxt;
      r_cause     <= w_cause_nxt;
    end
  end

  assign reset_out = r_reset_out;
  assign busy      = r_busy;
  assign done      = r_done;
  assign cause     = r_cause;

endmodule
